apb2axi_rdf: RTL and testbench

//  Read-data FIFO between the AXI R-channel collector and the APB register file.
//  - Buffers AXI read beats per tag and notifies the directory when a burst completes.
//  - Serves the register file one APB word per request, splitting each AXI beat into APB-width words.
//  - Frees the tag buffer once the register file pops the last word.

---
 rtl/apb2axi_pkg.sv | 52 +++++
 rtl/apb2axi_rdf_mem.sv | 47 ++++
 rtl/apb2axi_rdf.sv | 236 +++++++++++++++++++++++
 tb/tb_apb2axi_rdf.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb2axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb2axi_pkg
//  Description : Shared types and constants for the APB-to-AXI bridge. This
//                slice holds the read-data FIFO (RDF) definitions: the serve
//                FSM encoding, the per-tag context record and the
//                word-per-beat ratio.
//  Revision    : 1.0 - initial RDF definitions
// ============================================================================
package apb2axi_pkg;

    // Default geometry of the read-data FIFO. The per-tag context record below
    // is sized from these values, so an RDF instance must use the same
    // MAX_BEATS and data widths.
    localparam int RDF_TAG_W      = 4;
    localparam int RDF_AXI_DATA_W = 64;
    localparam int RDF_APB_DATA_W = 32;
    localparam int RDF_MAX_BEATS  = 16;

    // APB words carried by one AXI beat.
    localparam int RDF_WPB    = RDF_AXI_DATA_W / RDF_APB_DATA_W;

    // Beat counters hold 0..MAX_BEATS inclusive, hence the extra bit.
    localparam int RDF_CNT_W  = $clog2(RDF_MAX_BEATS) + 1;
    localparam int RDF_WIDX_W = (RDF_WPB > 1) ? $clog2(RDF_WPB) : 1;

    localparam logic [1:0] RDF_RESP_OKAY   = 2'b00;
    localparam logic [1:0] RDF_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_FETCH   = 2'd2,
        S_PRESENT = 2'd3
    } rdf_state_e;

    typedef struct packed {
        logic [RDF_CNT_W-1:0]  wcnt;       // beats stored (saturates at MAX_BEATS)
        logic [RDF_CNT_W-1:0]  rptr_beat;  // next beat to serve
        logic [RDF_WIDX_W-1:0] rptr_word;  // next word within that beat
        logic                  done;       // r_last seen, waiting for drain
        logic                  ovf;        // at least one beat dropped
        logic [1:0]            resp;       // worst response seen
    } rdf_tag_ctx_t;

    // AXI responses are ordered by severity, so the worst is the numeric max.
    function automatic logic [1:0] rdf_resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb2axi_rdf_mem.sv
`default_nettype none
// ============================================================================
//  Module      : apb2axi_rdf_mem
//  Description : Simple dual-port RAM backing the read-data FIFO. One write
//                port, one read port, registered read data (1-cycle latency).
//                The array has no reset; contents are only ever read after
//                being written.
//  Ports       : clk      - clock
//                i_we     - write enable
//                i_waddr  - write address
//                i_wdata  - write data
//                i_re     - read enable
//                i_raddr  - read address
//                o_rdata  - read data, valid the cycle after i_re
//  Revision    : 1.0 - initial version
// ============================================================================
module apb2axi_rdf_mem #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/apb2axi_rdf.sv
`default_nettype none
// ============================================================================
//  Module      : apb2axi_rdf
//  Description : Read-data FIFO between the AXI R-channel collector and the
//                APB register file. Buffers R beats per tag, signals the
//                directory when a burst is fully buffered, and serves the
//                register file one APB word per request. A tag buffer is
//                released when its last word is popped.
//  Ports       : pclk / preset            - clock, async active-high reset
//                r_vld/r_ready/r_data/
//                r_tag/r_resp/r_last      - AXI R-beat input
//                rdf_reg_data_req/_tag    - request next word of a tag
//                rdf_reg_data_vld/_ready/
//                _out/_last               - word presentation and pop
//                rdf_dir_done_vld/_tag/
//                _resp                    - burst-complete notification
//  Revision    : 1.0 - initial version
// ============================================================================
module apb2axi_rdf
    import apb2axi_pkg::*;
#(
    parameter int TAG_W      = RDF_TAG_W,
    parameter int AXI_DATA_W = RDF_AXI_DATA_W,
    parameter int APB_DATA_W = RDF_APB_DATA_W,
    parameter int MAX_BEATS  = RDF_MAX_BEATS
) (
    input  logic                  pclk,
    input  logic                  preset,
    // AXI R channel
    input  logic                  r_vld,
    output logic                  r_ready,
    input  logic [AXI_DATA_W-1:0] r_data,
    input  logic [TAG_W-1:0]      r_tag,
    input  logic [1:0]            r_resp,
    input  logic                  r_last,
    // Register-file word interface
    input  logic                  rdf_reg_data_req,
    input  logic [TAG_W-1:0]      rdf_reg_data_req_tag,
    output logic                  rdf_reg_data_vld,
    input  logic                  rdf_reg_data_ready,
    output logic [APB_DATA_W-1:0] rdf_reg_data_out,
    output logic                  rdf_reg_data_last,
    // Directory notification
    output logic                  rdf_dir_done_vld,
    output logic [TAG_W-1:0]      rdf_dir_done_tag,
    output logic [1:0]            rdf_dir_done_resp
);

    localparam int NUM_TAGS = 2 ** TAG_W;
    localparam int BEAT_W   = $clog2(MAX_BEATS);
    localparam int ADDR_W   = TAG_W + BEAT_W;

    localparam logic [RDF_CNT_W-1:0]  MAX_CNT   = RDF_CNT_W'(MAX_BEATS);
    localparam logic [RDF_CNT_W-1:0]  CNT_ONE   = RDF_CNT_W'(1);
    localparam logic [RDF_WIDX_W-1:0] LAST_WORD = RDF_WIDX_W'(RDF_WPB - 1);
    localparam logic [RDF_WIDX_W-1:0] WORD_ONE  = RDF_WIDX_W'(1);

    // ------------------------------------------------------------------
    // Per-tag context
    // ------------------------------------------------------------------
    rdf_tag_ctx_t r_ctx [NUM_TAGS];

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    rdf_tag_ctx_t w_wr_ctx;
    logic         w_wr_accept;
    logic         w_wr_store;
    logic         w_wr_ovf;
    logic [1:0]   w_wr_resp;
    logic [ADDR_W-1:0] w_waddr;

    assign w_wr_ctx    = r_ctx[r_tag];
    // A completed but undrained tag holds off new beats for that tag only.
    assign r_ready     = ~w_wr_ctx.done;
    assign w_wr_accept = r_vld & r_ready;
    // Once the buffer is full the beat is still accepted so the AXI side
    // never stalls, but its data is discarded and the burst is flagged.
    assign w_wr_store  = w_wr_accept & (w_wr_ctx.wcnt < MAX_CNT);
    assign w_wr_ovf    = w_wr_ctx.ovf | (w_wr_accept & ~w_wr_store);
    assign w_wr_resp   = rdf_resp_max(w_wr_ctx.resp, r_resp);
    assign w_waddr     = {r_tag, w_wr_ctx.wcnt[BEAT_W-1:0]};

    logic             r_done_vld;
    logic [TAG_W-1:0] r_done_tag;
    logic [1:0]       r_done_resp;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_done_vld  <= 1'b0;
            r_done_tag  <= '0;
            r_done_resp <= '0;
        end else begin
            r_done_vld <= w_wr_accept & r_last;
            if (w_wr_accept && r_last) begin
                r_done_tag  <= r_tag;
                r_done_resp <= w_wr_ovf ? RDF_RESP_SLVERR : w_wr_resp;
            end
        end
    end

    assign rdf_dir_done_vld  = r_done_vld;
    assign rdf_dir_done_tag  = r_done_tag;
    assign rdf_dir_done_resp = r_done_resp;

    // ------------------------------------------------------------------
    // Serve FSM
    // ------------------------------------------------------------------
    rdf_state_e       r_state;
    rdf_state_e       w_next_state;
    logic [TAG_W-1:0] r_cur_tag;
    rdf_tag_ctx_t     w_cur_ctx;
    logic             w_avail;
    logic             w_last;
    logic             w_pop;
    logic             w_rd_en;
    logic [ADDR_W-1:0] w_raddr;

    assign w_cur_ctx = r_ctx[r_cur_tag];
    // Uses the registered count, so a beat written this cycle is seen next cycle.
    assign w_avail   = w_cur_ctx.rptr_beat < w_cur_ctx.wcnt;
    // wcnt saturates at MAX_BEATS, so it already equals min(wcnt, MAX_BEATS).
    assign w_last    = w_cur_ctx.done
                     & (w_cur_ctx.rptr_beat == (w_cur_ctx.wcnt - CNT_ONE))
                     & (w_cur_ctx.rptr_word == LAST_WORD);
    // A new request takes priority over a pop in the same cycle: the
    // presentation is abandoned and the word stays unconsumed.
    assign w_pop     = (r_state == S_PRESENT) & rdf_reg_data_ready & ~rdf_reg_data_req;
    assign w_rd_en   = (r_state == S_WAIT) & w_avail & ~rdf_reg_data_req;
    assign w_raddr   = {r_cur_tag, w_cur_ctx.rptr_beat[BEAT_W-1:0]};

    always_comb begin
        w_next_state = r_state;
        if (rdf_reg_data_req) begin
            w_next_state = S_WAIT;
        end else begin
            case (r_state)
                S_IDLE:    w_next_state = S_IDLE;
                S_WAIT:    if (w_avail) w_next_state = S_FETCH;
                S_FETCH:   w_next_state = S_PRESENT;
                S_PRESENT: if (rdf_reg_data_ready) w_next_state = S_IDLE;
                default:   w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state   <= S_IDLE;
            r_cur_tag <= '0;
        end else begin
            r_state <= w_next_state;
            if (rdf_reg_data_req) begin
                r_cur_tag <= rdf_reg_data_req_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // Beat storage and word selection
    // ------------------------------------------------------------------
    logic [AXI_DATA_W-1:0] w_mem_rdata;

    apb2axi_rdf_mem #(
        .DATA_W (AXI_DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (pclk),
        .i_we    (w_wr_store),
        .i_waddr (w_waddr),
        .i_wdata (r_data),
        .i_re    (w_rd_en),
        .i_raddr (w_raddr),
        .o_rdata (w_mem_rdata)
    );

    logic [APB_DATA_W-1:0] w_words [RDF_WPB];

    generate
        for (genvar g = 0; g < RDF_WPB; g++) begin : g_words
            assign w_words[g] = w_mem_rdata[g*APB_DATA_W +: APB_DATA_W];
        end
    endgenerate

    // The word is captured once on leaving FETCH so it stays stable for the
    // whole presentation regardless of later RAM activity.
    logic [APB_DATA_W-1:0] r_data_out;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_data_out <= '0;
        end else if (r_state == S_FETCH) begin
            r_data_out <= w_words[w_cur_ctx.rptr_word];
        end
    end

    assign rdf_reg_data_vld  = (r_state == S_PRESENT);
    assign rdf_reg_data_out  = r_data_out;
    assign rdf_reg_data_last = (r_state == S_PRESENT) & w_last;

    // ------------------------------------------------------------------
    // Context update. Write and pop never touch the same field of the same
    // tag at once: a pop-with-last needs done=1, which blocks writes to that
    // tag, and a plain pop only moves the read pointers.
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int t = 0; t < NUM_TAGS; t++) begin
                r_ctx[t] <= '0;
            end
        end else begin
            if (w_wr_accept) begin
                if (w_wr_store) begin
                    r_ctx[r_tag].wcnt <= w_wr_ctx.wcnt + CNT_ONE;
                end
                r_ctx[r_tag].ovf  <= w_wr_ovf;
                r_ctx[r_tag].resp <= w_wr_resp;
                if (r_last) begin
                    r_ctx[r_tag].done <= 1'b1;
                end
            end
            if (w_pop) begin
                if (w_last) begin
                    r_ctx[r_cur_tag] <= '0;
                end else if (w_cur_ctx.rptr_word == LAST_WORD) begin
                    r_ctx[r_cur_tag].rptr_word <= '0;
                    r_ctx[r_cur_tag].rptr_beat <= w_cur_ctx.rptr_beat + CNT_ONE;
                end else begin
                    r_ctx[r_cur_tag].rptr_word <= w_cur_ctx.rptr_word + WORD_ONE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb2axi_rdf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb2axi_rdf
//  Description : Self-checking bench for apb2axi_rdf. Drivers push expected
//                words / completions into queues; monitors pop and compare
//                whenever the DUT pops a word or pulses a completion.
//  Revision    : 1.0 - initial version
// ============================================================================
module tb_apb2axi_rdf;

    localparam int TAG_W = 4;
    localparam int AXI_W = 64;
    localparam int APB_W = 32;
    localparam int MB    = 16;

    logic             pclk;
    logic             preset;
    logic             r_vld;
    logic             r_ready;
    logic [AXI_W-1:0] r_data;
    logic [TAG_W-1:0] r_tag;
    logic [1:0]       r_resp;
    logic             r_last;
    logic             req;
    logic [TAG_W-1:0] req_tag;
    logic             vld;
    logic             ready;
    logic [APB_W-1:0] dout;
    logic             dlast;
    logic             done_vld;
    logic [TAG_W-1:0] done_tag;
    logic [1:0]       done_resp;

    apb2axi_rdf #(
        .TAG_W      (TAG_W),
        .AXI_DATA_W (AXI_W),
        .APB_DATA_W (APB_W),
        .MAX_BEATS  (MB)
    ) dut (
        .pclk                 (pclk),
        .preset               (preset),
        .r_vld                (r_vld),
        .r_ready              (r_ready),
        .r_data               (r_data),
        .r_tag                (r_tag),
        .r_resp               (r_resp),
        .r_last               (r_last),
        .rdf_reg_data_req     (req),
        .rdf_reg_data_req_tag (req_tag),
        .rdf_reg_data_vld     (vld),
        .rdf_reg_data_ready   (ready),
        .rdf_reg_data_out     (dout),
        .rdf_reg_data_last    (dlast),
        .rdf_dir_done_vld     (done_vld),
        .rdf_dir_done_tag     (done_tag),
        .rdf_dir_done_resp    (done_resp)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int errors = 0;
    int checks = 0;

    typedef struct packed { logic [APB_W-1:0] data; logic last; } word_t;
    typedef struct packed { logic [TAG_W-1:0] tag; logic [1:0] resp; } done_t;

    word_t exp_words [$];
    done_t exp_done  [$];
    word_t mon_w;
    done_t mon_d;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge pclk) begin
        if (!preset) begin
            if (vld && ready) begin
                if (exp_words.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word_pop: unexpected word %0h last %0b", dout, dlast);
                end else begin
                    mon_w = exp_words.pop_front();
                    check("word_data", 64'(dout), 64'(mon_w.data));
                    check("word_last", 64'(dlast), 64'(mon_w.last));
                end
            end
            if (done_vld) begin
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_pulse: unexpected tag %0d resp %0d", done_tag, done_resp);
                end else begin
                    mon_d = exp_done.pop_front();
                    check("done_tag", 64'(done_tag), 64'(mon_d.tag));
                    check("done_resp", 64'(done_resp), 64'(mon_d.resp));
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic send_beat(input logic [TAG_W-1:0] tag, input logic [AXI_W-1:0] data,
                             input logic [1:0] resp, input logic last, input logic [1:0] exp_resp);
        bit ok;
        r_vld  = 1'b1;
        r_tag  = tag;
        r_data = data;
        r_resp = resp;
        r_last = last;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            if (r_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge pclk);
        end
        if (!ok) check("beat_accept_timeout", 64'(r_ready), 64'd1);
        else if (last) exp_done.push_back('{tag: tag, resp: exp_resp});
        step();
        r_vld  = 1'b0;
        r_last = 1'b0;
    endtask

    // Returns cycles waited (starting from the current cycle) until vld is seen.
    task automatic wait_vld(output int k, output bit ok);
        k  = 0;
        ok = 1'b0;
        while (k < 40) begin
            if (vld) begin
                ok = 1'b1;
                break;
            end
            step();
            k++;
        end
        if (!ok) check("vld_timeout", 64'(vld), 64'd1);
    endtask

    task automatic pop_now(input logic [APB_W-1:0] data, input logic last);
        exp_words.push_back('{data: data, last: last});
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("vld_drop_after_pop", 64'(vld), 64'd0);
    endtask

    // exp_lat: cycles from the request cycle to the first vld cycle (0 = unchecked).
    task automatic serve(input logic [TAG_W-1:0] tag, input logic [APB_W-1:0] data,
                         input logic last, input int exp_lat);
        int k;
        bit ok;
        req     = 1'b1;
        req_tag = tag;
        step();
        req = 1'b0;
        wait_vld(k, ok);
        if (ok) begin
            if (exp_lat != 0) check("serve_latency", 64'(k + 1), 64'(exp_lat));
            pop_now(data, last);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit ok;
        preset  = 1'b1;
        r_vld   = 1'b0;
        r_data  = '0;
        r_tag   = '0;
        r_resp  = '0;
        r_last  = 1'b0;
        req     = 1'b0;
        req_tag = '0;
        ready   = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_vld", 64'(vld), 64'd0);
        check("rst_out", 64'(dout), 64'd0);
        check("rst_last", 64'(dlast), 64'd0);
        check("rst_done_vld", 64'(done_vld), 64'd0);
        check("rst_done_tag", 64'(done_tag), 64'd0);
        check("rst_done_resp", 64'(done_resp), 64'd0);
        check("rst_r_ready", 64'(r_ready), 64'd1);
        preset = 1'b0;
        step();

        // Single burst on tag 3
        send_beat(4'd3, 64'h1111_2222_3333_4444, 2'b00, 1'b0, 2'b00);
        send_beat(4'd3, 64'h5555_6666_7777_8888, 2'b00, 1'b1, 2'b00);
        serve(4'd3, 32'h3333_4444, 1'b0, 3);
        serve(4'd3, 32'h1111_2222, 1'b0, 0);
        serve(4'd3, 32'h7777_8888, 1'b0, 0);
        serve(4'd3, 32'h5555_6666, 1'b1, 0);

        // Early request on tag 5: waits for the beat
        req     = 1'b1;
        req_tag = 4'd5;
        step();
        req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("early_vld_idle", 64'(vld), 64'd0);
            step();
        end
        send_beat(4'd5, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 1'b1, 2'b00);
        check("early_vld_c1", 64'(vld), 64'd0);
        step();
        check("early_vld_c2", 64'(vld), 64'd0);
        step();
        check("early_vld_c3", 64'(vld), 64'd1);
        if (vld) pop_now(32'hCCCC_DDDD, 1'b0);
        serve(4'd5, 32'hAAAA_BBBB, 1'b1, 3);

        // Interleaved tags 1 and 2
        send_beat(4'd1, 64'hA1A1_0001_A1A1_0000, 2'b00, 1'b0, 2'b00);
        send_beat(4'd2, 64'hB2B2_0001_B2B2_0000, 2'b01, 1'b0, 2'b00);
        send_beat(4'd1, 64'hA1A1_0003_A1A1_0002, 2'b00, 1'b1, 2'b00);
        send_beat(4'd2, 64'hB2B2_0003_B2B2_0002, 2'b00, 1'b1, 2'b01);
        serve(4'd2, 32'hB2B2_0000, 1'b0, 3);
        serve(4'd1, 32'hA1A1_0000, 1'b0, 0);
        serve(4'd1, 32'hA1A1_0001, 1'b0, 0);
        serve(4'd2, 32'hB2B2_0001, 1'b0, 0);
        serve(4'd2, 32'hB2B2_0002, 1'b0, 0);
        serve(4'd1, 32'hA1A1_0002, 1'b0, 0);
        serve(4'd1, 32'hA1A1_0003, 1'b1, 0);
        serve(4'd2, 32'hB2B2_0003, 1'b1, 0);

        // Backpressure on tag 7
        send_beat(4'd7, 64'h7777_0001_7777_0000, 2'b00, 1'b1, 2'b00);
        r_vld  = 1'b1;
        r_tag  = 4'd7;
        r_data = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge pclk);
        check("bp_r_ready_low", 64'(r_ready), 64'd0);
        step();
        r_vld = 1'b0;
        serve(4'd7, 32'h7777_0000, 1'b0, 0);
        check("bp_r_ready_mid", 64'(r_ready), 64'd0);
        serve(4'd7, 32'h7777_0001, 1'b1, 0);
        check("bp_r_ready_release", 64'(r_ready), 64'd1);

        // Overflow: 18 beats on tag 0, only 16 kept
        for (int i = 0; i < 18; i++) begin
            send_beat(4'd0, {32'hF000_0000 | 32'(2*i+1), 32'hF000_0000 | 32'(2*i)},
                      2'b00, (i == 17), 2'b10);
        end
        for (int w = 0; w < 32; w++) begin
            serve(4'd0, 32'hF000_0000 | 32'(w), (w == 31), 0);
        end
        send_beat(4'd0, 64'hC0DE_0001_C0DE_0000, 2'b00, 1'b1, 2'b00);
        serve(4'd0, 32'hC0DE_0000, 1'b0, 3);
        serve(4'd0, 32'hC0DE_0001, 1'b1, 0);

        // Abort: tag 4 presentation replaced by tag 6, tag 4 re-served later
        send_beat(4'd4, 64'h4444_0001_4444_0000, 2'b00, 1'b1, 2'b00);
        send_beat(4'd6, 64'h6666_0001_6666_0000, 2'b11, 1'b1, 2'b11);
        req     = 1'b1;
        req_tag = 4'd4;
        step();
        req = 1'b0;
        wait_vld(k, ok);
        check("abort_first_lat", 64'(k + 1), 64'd3);
        check("abort_first_data", 64'(dout), 64'h4444_0000);
        req     = 1'b1;
        req_tag = 4'd6;
        step();
        req = 1'b0;
        check("abort_vld_drop", 64'(vld), 64'd0);
        wait_vld(k, ok);
        check("abort_second_lat", 64'(k + 1), 64'd3);
        if (ok) pop_now(32'h6666_0000, 1'b0);
        serve(4'd6, 32'h6666_0001, 1'b1, 3);
        serve(4'd4, 32'h4444_0000, 1'b0, 3);
        serve(4'd4, 32'h4444_0001, 1'b1, 0);

        // Reset while presenting
        send_beat(4'd9, 64'h9999_0001_9999_0000, 2'b00, 1'b1, 2'b00);
        r_tag   = 4'd9;
        req     = 1'b1;
        req_tag = 4'd9;
        step();
        req = 1'b0;
        wait_vld(k, ok);
        check("rst_mid_r_ready_before", 64'(r_ready), 64'd0);
        preset = 1'b1;
        #1;
        check("rst_mid_vld", 64'(vld), 64'd0);
        check("rst_mid_r_ready", 64'(r_ready), 64'd1);
        check("rst_mid_out", 64'(dout), 64'd0);
        step();
        preset = 1'b0;
        step();
        send_beat(4'd9, 64'h9A9A_0001_9A9A_0000, 2'b01, 1'b1, 2'b01);
        serve(4'd9, 32'h9A9A_0000, 1'b0, 3);
        serve(4'd9, 32'h9A9A_0001, 1'b1, 0);

        repeat (4) step();
        check("words_drained", 64'(exp_words.size()), 64'd0);
        check("done_drained", 64'(exp_done.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
